// File: rtl/thirty_two_to_eight.sv
// thirty_two_to_eight: serialises one 12-bit payload into a 4-byte frame
// {4'hA, P[11:0], 16'hBEAF}. The frame is sent MSB byte first on div_8_clk.
// At least one IDLE_BYTE cycle (GAP) always separates two frames.
// Optional build macro: TX_SKID_EN. It adds a one-entry holding register so
// the next word can be accepted while a frame is still being sent.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state (and rst_n). in_payload and
// in_valid are ignored while in_ready is low.
module thirty_two_to_eight #(
   parameter logic [7:0] IDLE_BYTE = 8'h00
) (
   input  logic        div_8_clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_payload,
   output logic [7:0]  data_out,
   output logic        tx_active,
   output logic        frame_done,
   output logic [2:0]  state_dbg
);

   // An idle byte whose top nibble is the frame marker would be mistaken for a frame start.
   generate
      if (IDLE_BYTE[7:4] == 4'hA) begin : g_idle_byte_check
         $error("IDLE_BYTE[7:4] must not be 4'hA");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      B0   = 3'd1,
      B1   = 3'd2,
      B2   = 3'd3,
      B3   = 3'd4,
      GAP  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] payload_q, payload_d;
   logic [7:0]  data_d;
   logic        tx_d, done_d;
   logic        hs;

`ifdef TX_SKID_EN
   logic        hold_valid_q, hold_valid_d;
   logic [11:0] hold_q, hold_d;
`endif

   assign state_dbg = state_q;
   assign hs        = in_valid && in_ready;

   // Ready decode: always open in IDLE, otherwise only when the holding register is free.
   always_comb begin
      in_ready = 1'b0;
      if (!rst_n)
         in_ready = 1'b0;
      else if (state_q == IDLE)
         in_ready = 1'b1;
`ifdef TX_SKID_EN
      else
         in_ready = !hold_valid_q;
`endif
   end

   // Next-state, payload selection and the registered-output values for the next cycle.
   always_comb begin
      state_d   = state_q;
      payload_d = payload_q;
`ifdef TX_SKID_EN
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (hs) begin
               state_d   = B0;
               payload_d = in_payload;
            end
         end
         B0:  state_d = B1;
         B1:  state_d = B2;
         B2:  state_d = B3;
         B3:  state_d = GAP;
         GAP: begin
`ifdef TX_SKID_EN
            if (hold_valid_q) begin
               state_d      = B0;
               payload_d    = hold_q;
               hold_valid_d = 1'b0;
            end else if (hs) begin
               state_d   = B0;
               payload_d = in_payload;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

`ifdef TX_SKID_EN
      // Words arriving during B0..B3 wait in the holding register until GAP.
      if (hs && (state_q inside {B0, B1, B2, B3})) begin
         hold_valid_d = 1'b1;
         hold_d       = in_payload;
      end
`endif

      data_d = IDLE_BYTE;
      tx_d   = 1'b0;
      done_d = 1'b0;
      case (state_d)
         B0: begin
            data_d = {4'hA, payload_d[11:8]};
            tx_d   = 1'b1;
         end
         B1: begin
            data_d = payload_d[7:0];
            tx_d   = 1'b1;
         end
         B2: begin
            data_d = 8'hBE;
            tx_d   = 1'b1;
         end
         B3: begin
            data_d = 8'hAF;
            tx_d   = 1'b1;
         end
         GAP:     done_d = 1'b1;
         default: ;
      endcase
   end

   // State and output registers; reset drops any frame in progress and any pending word.
   always_ff @(posedge div_8_clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         payload_q  <= '0;
         data_out   <= IDLE_BYTE;
         tx_active  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         payload_q  <= payload_d;
         data_out   <= data_d;
         tx_active  <= tx_d;
         frame_done <= done_d;
      end
   end

`ifdef TX_SKID_EN
   // One-entry holding register for the word accepted during a frame.
   always_ff @(posedge div_8_clk) begin
      if (!rst_n) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
      end
   end
`endif

endmodule

// File: tb/tb_thirty_two_to_eight.sv
// Directed bench for thirty_two_to_eight. Two instances share the same stimulus:
// one with the default IDLE_BYTE and one with IDLE_BYTE = 8'h55.
module tb_thirty_two_to_eight;

   typedef struct {
      logic       f;
      logic [7:0] b;
      logic       d;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [11:0] in_payload;
   logic        in_ready, in_ready55;
   logic [7:0]  data_out, data55;
   logic        tx_active, tx55;
   logic        frame_done, done55;
   logic [2:0]  state_dbg, state55;

   int n_checks = 0;
   int n_pass   = 0;

   thirty_two_to_eight u_dut (
      .div_8_clk  (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_payload (in_payload),
      .data_out   (data_out),
      .tx_active  (tx_active),
      .frame_done (frame_done),
      .state_dbg  (state_dbg)
   );

   thirty_two_to_eight #(.IDLE_BYTE(8'h55)) u_dut55 (
      .div_8_clk  (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready55),
      .in_payload (in_payload),
      .data_out   (data55),
      .tx_active  (tx55),
      .frame_done (done55),
      .state_dbg  (state55)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Checking task
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Advance one cycle; everything is sampled and driven 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected output of both instances for one cycle.
   task automatic cyc(input string tag, input logic frame, input logic [7:0] b, input logic done);
      chk(tag, {22'd0, tx_active, frame_done, data_out},
          {22'd0, frame, done, (frame ? b : 8'h00)});
      chk({tag, "_55"}, {22'd0, tx55, done55, data55},
          {22'd0, frame, done, (frame ? b : 8'h55)});
   endtask

   exp_t        seq[$];
   logic [11:0] pl[$];
   logic        hs;
   logic [31:0] sr;
   int          frames;
   int          acc;

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_payload = 12'h000;

      // Reset state
      step();
      step();
      cyc("rst", 1'b0, 8'h00, 1'b0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_ready_55", {31'd0, in_ready55}, 32'd0);
      chk("rst_state", {29'd0, state_dbg}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", {31'd0, in_ready}, 32'd1);

      // Single frame, payload 12'h5C3
      in_valid   = 1'b1;
      in_payload = 12'h5C3;
      step();
      in_valid = 1'b0;
      cyc("s_b0", 1'b1, 8'hA5, 1'b0);
`ifdef TX_SKID_EN
      chk("s_b0_ready", {31'd0, in_ready}, 32'd1);
`else
      chk("s_b0_ready", {31'd0, in_ready}, 32'd0);
`endif
      step(); cyc("s_b1", 1'b1, 8'hC3, 1'b0);
      step(); cyc("s_b2", 1'b1, 8'hBE, 1'b0);
      step(); cyc("s_b3", 1'b1, 8'hAF, 1'b0);
      step(); cyc("s_gap", 1'b0, 8'h00, 1'b1);
      step(); cyc("s_idle", 1'b0, 8'h00, 1'b0);

      // Back-to-back with in_valid held high: 12'h123 then 12'h456
      seq.push_back('{1'b1, 8'hA1, 1'b0});
      seq.push_back('{1'b1, 8'h23, 1'b0});
      seq.push_back('{1'b1, 8'hBE, 1'b0});
      seq.push_back('{1'b1, 8'hAF, 1'b0});
      seq.push_back('{1'b0, 8'h00, 1'b1});
`ifndef TX_SKID_EN
      seq.push_back('{1'b0, 8'h00, 1'b0});
`endif
      seq.push_back('{1'b1, 8'hA4, 1'b0});
      seq.push_back('{1'b1, 8'h56, 1'b0});
      seq.push_back('{1'b1, 8'hBE, 1'b0});
      seq.push_back('{1'b1, 8'hAF, 1'b0});
      seq.push_back('{1'b0, 8'h00, 1'b1});
      pl.push_back(12'h123);
      pl.push_back(12'h456);
      in_valid   = 1'b1;
      in_payload = pl[0];
      for (int i = 0; i < seq.size(); i++) begin
         hs = in_valid && in_ready;
         step();
         if (hs) begin
            void'(pl.pop_front());
            if (pl.size() > 0) in_payload = pl[0];
            else in_valid = 1'b0;
         end
         cyc($sformatf("b2b_%0d", i), seq[i].f, seq[i].b, seq[i].d);
      end
      in_valid = 1'b0;
      step(); cyc("b2b_idle", 1'b0, 8'h00, 1'b0);

      // Backpressure: a pulse during B2 must not be taken
      in_valid   = 1'b1;
      in_payload = 12'h7E1;
      step();
      in_valid = 1'b0;
      cyc("bp_b0", 1'b1, 8'hA7, 1'b0);
      step(); cyc("bp_b1", 1'b1, 8'hE1, 1'b0);
      step(); cyc("bp_b2", 1'b1, 8'hBE, 1'b0);
`ifdef TX_SKID_EN
      chk("bp_ready", {31'd0, in_ready}, 32'd1);
`else
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      in_valid   = 1'b1;
      in_payload = 12'hFFF;
`endif
      step();
      in_valid = 1'b0;
      cyc("bp_b3", 1'b1, 8'hAF, 1'b0);
      step(); cyc("bp_gap", 1'b0, 8'h00, 1'b1);
      step(); cyc("bp_idle0", 1'b0, 8'h00, 1'b0);
      step(); cyc("bp_idle1", 1'b0, 8'h00, 1'b0);

      // Reset in the B1 cycle abandons the frame
      in_valid   = 1'b1;
      in_payload = 12'h3A9;
      step();
      in_valid = 1'b0;
      cyc("rm_b0", 1'b1, 8'hA3, 1'b0);
      step(); cyc("rm_b1", 1'b1, 8'hA9, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rm_ready_in_rst", {31'd0, in_ready}, 32'd0);
      step(); cyc("rm_rst", 1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         cyc($sformatf("rm_after_%0d", i), 1'b0, 8'h00, 1'b0);
      end
      chk("rm_state", {29'd0, state_dbg}, 32'd0);

      // Loopback: a bench-side receiver reassembles each frame
      sr         = 32'd0;
      frames     = 0;
      acc        = 0;
      in_valid   = 1'b1;
      in_payload = 12'h5C3;
      for (int c = 0; c < 40 && frames < 3; c++) begin
         hs = in_valid && in_ready;
         step();
         if (hs) begin
            acc++;
            if (acc == 3) in_valid = 1'b0;
         end
         if (tx_active) sr = {sr[23:0], data_out};
         if (frame_done) begin
            chk($sformatf("loop_word_%0d", frames), sr, 32'hA5C3BEAF);
            frames++;
         end
      end
      in_valid = 1'b0;
      chk("loop_frames", frames, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
